// File: rtl/bd_shift_seq.sv
// bd_shift_seq: command sequencer for a 4-bit bidirectional shift register.
// Feeds serial bits, pulses shift_en, captures exiting bits, returns a response.
module bd_shift_seq #(
    parameter int WIDTH  = 4,
    parameter int MAXLEN = 16,
    parameter int LENW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [LENW-1:0]   cmd_len,
    input  logic [MAXLEN-1:0] cmd_data,
    input  logic              abort,
    input  logic [WIDTH-1:0]  sr_q,
    output logic              mode,
    output logic              dr,
    output logic              dl,
    output logic              shift_en,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [MAXLEN-1:0] rsp_data,
    output logic [LENW-1:0]   rsp_count,
    output logic              rsp_aborted
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    localparam logic [LENW-1:0]  MAXL    = LENW'(MAXLEN);
    localparam logic [WIDTH-1:0] LSB_MSK = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_MSK = WIDTH'(1) << (WIDTH - 1);

    state_t state;
    state_t state_nx;

    logic              dir_q;
    logic [LENW-1:0]   len_q;
    logic [LENW-1:0]   k_q;
    logic [MAXLEN-1:0] data_q;
    logic [MAXLEN-1:0] cap_q;
    logic              abt_q;

    logic [LENW-1:0] len_clamp;
    logic            exit_bit;
    logic            last_shift;

    assign len_clamp  = (cmd_len > MAXL) ? MAXL : cmd_len;
    // data_q is consumed from bit 0, so data_q[0] is always data[k]
    assign exit_bit   = dir_q ? |(sr_q & LSB_MSK) : |(sr_q & MSB_MSK);
    assign last_shift = (k_q == len_q - 1'b1);

    assign rsp_data    = cap_q;
    assign rsp_count   = k_q;
    assign rsp_aborted = abt_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control outputs decoded from state and latched command
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        mode      = dir_q;
        dr        = 1'b0;
        dl        = 1'b0;
        shift_en  = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                mode      = 1'b0;
                if (cmd_valid) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (abort || len_q == '0) begin
                    state_nx = DONE;
                end else begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = !abort;
                dr       = dir_q & data_q[0];
                dl       = !dir_q & data_q[0];
                if (abort || last_shift) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Command latch, serial feed, capture and shift count
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q  <= 1'b0;
            len_q  <= '0;
            k_q    <= '0;
            data_q <= '0;
            cap_q  <= '0;
            abt_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir_q  <= cmd_dir;
                        len_q  <= len_clamp;
                        data_q <= cmd_data;
                        k_q    <= '0;
                        cap_q  <= '0;
                        abt_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (abort) begin
                        abt_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        abt_q <= 1'b1;
                    end else begin
                        cap_q  <= cap_q | (MAXLEN'(exit_bit) << k_q);
                        k_q    <= k_q + 1'b1;
                        data_q <= data_q >> 1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
